zxw_cam_match_scanner: RTL and testbench

//  Search-side controller for the 16x6 zxw CAM. Accepts a search key, drives it

---
 rtl/zxw_cam_match_scanner.sv | 148 ++++++++++++++
 tb/tb_zxw_cam_match_scanner.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zxw_cam_match_scanner.sv
// Search-side controller for the 16x6 zxw CAM: drives the key onto argin, waits for
// match lines to settle, snapshots mbits and streams matching addresses low-to-high.
module zxw_cam_match_scanner #(
  parameter int DW     = 6,
  parameter int DEPTH  = 16,
  parameter int AW     = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srch_req,
  input  logic [DW-1:0]    srch_key,
  output logic             srch_busy,
  output logic [DW-1:0]    cam_argin,
  input  logic [DEPTH-1:0] cam_mbits,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [AW-1:0]    m_addr,
  output logic             m_last,
  output logic             done,
  output logic             hit,
  output logic [AW:0]      match_cnt
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPT,
    ST_EMIT,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    ctr_reg, ctr_next;
  logic [DEPTH-1:0] vec_reg, vec_next;
  logic [DW-1:0]    argin_reg, argin_next;
  logic             hit_reg, hit_next;
  logic [AW:0]      cnt_reg, cnt_next;

  logic [DEPTH-1:0] low_bit;
  logic             one_left;
  logic [AW-1:0]    enc_addr;
  logic [AW:0]      pop_cnt;

  // Two's-complement trick isolates the lowest pending match as a one-hot word.
  assign low_bit  = vec_reg & (~vec_reg + DEPTH'(1));
  assign one_left = ((vec_reg & (vec_reg - DEPTH'(1))) == '0);

  // One-hot to binary: address bit gi is the OR of all one-hot lines whose index has bit gi set.
  genvar gi, gj;
  generate
    for (gi = 0; gi < AW; gi++) begin : g_enc
      logic [DEPTH-1:0] sel;
      for (gj = 0; gj < DEPTH; gj++) begin : g_line
        if (((gj >> gi) % 2) == 1) begin : g_on
          assign sel[gj] = low_bit[gj];
        end else begin : g_off
          assign sel[gj] = 1'b0;
        end
      end
      assign enc_addr[gi] = |sel;
    end
  endgenerate

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop_cnt = pop_cnt + (AW+1)'(cam_mbits[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ctr_reg   <= '0;
      vec_reg   <= '0;
      argin_reg <= '0;
      hit_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ctr_reg   <= ctr_next;
      vec_reg   <= vec_next;
      argin_reg <= argin_next;
      hit_reg   <= hit_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ctr_next   = ctr_reg;
    vec_next   = vec_reg;
    argin_next = argin_reg;
    hit_next   = hit_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (srch_req) begin
          argin_next = srch_key;
          ctr_next   = CW'(SETTLE - 1);
          state_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (ctr_reg == '0) begin
          state_next = ST_CAPT;
        end else begin
          ctr_next = ctr_reg - CW'(1);
        end
      end
      ST_CAPT: begin
        // Snapshot only here, so CAM writes during the emit phase cannot disturb this search.
        vec_next   = cam_mbits;
        cnt_next   = pop_cnt;
        hit_next   = |cam_mbits;
        state_next = (|cam_mbits) ? ST_EMIT : ST_DONE;
      end
      ST_EMIT: begin
        if (m_ready) begin
          vec_next = vec_reg & ~low_bit;
          if (one_left) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Stream and status outputs decode straight from state so an async reset drops them at once.
  assign srch_busy = (state_reg != ST_IDLE);
  assign m_valid   = (state_reg == ST_EMIT);
  assign m_last    = (state_reg == ST_EMIT) && one_left;
  assign m_addr    = enc_addr;
  assign done      = (state_reg == ST_DONE);
  assign cam_argin = argin_reg;
  assign hit       = hit_reg;
  assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_zxw_cam_match_scanner.sv
// Directed bench for zxw_cam_match_scanner: table of searches against forced match
// vectors or a behavioural 16x6 CAM, plus a mid-emit asynchronous reset sequence.
module tb_zxw_cam_match_scanner;

  localparam int DW     = 6;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int SETTLE = 2;
  localparam int NVEC   = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             srch_req;
  logic [DW-1:0]    srch_key;
  logic             srch_busy;
  logic [DW-1:0]    cam_argin;
  logic [DEPTH-1:0] cam_mbits;
  logic             m_valid;
  logic             m_ready;
  logic [AW-1:0]    m_addr;
  logic             m_last;
  logic             done;
  logic             hit;
  logic [AW:0]      match_cnt;

  // Behavioural CAM and forced-vector source
  logic             use_cam;
  logic [DEPTH-1:0] force_mbits;
  logic             cam_we_n;
  logic [AW-1:0]    cam_wa;
  logic [DW-1:0]    cam_din;
  logic [DW-1:0]    cam_mem [DEPTH];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!cam_we_n) cam_mem[cam_wa] <= cam_din;
  end

  always_comb begin
    cam_mbits = force_mbits;
    if (use_cam) begin
      for (int i = 0; i < DEPTH; i++) cam_mbits[i] = (cam_mem[i] == cam_argin);
    end
  end

  zxw_cam_match_scanner #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .srch_req  (srch_req),
    .srch_key  (srch_key),
    .srch_busy (srch_busy),
    .cam_argin (cam_argin),
    .cam_mbits (cam_mbits),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_addr    (m_addr),
    .m_last    (m_last),
    .done      (done),
    .hit       (hit),
    .match_cnt (match_cnt)
  );

  typedef struct {
    logic        use_cam;
    logic [5:0]  key;
    logic [15:0] mbits;
    logic [15:0] rdy;    // m_ready for cycle c is rdy[c % 16]
    int          n;      // expected beat count
    logic [63:0] addrs;  // expected address of beat k in nibble k
    logic [4:0]  cnt;
    logic        hit;
    logic [1:0]  inj;    // 1: stray srch_req during emit, 2: CAM write to entry 5 during emit
  } vec_t;

  vec_t tv [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_search(input int idx);
    vec_t       r;
    int         cyc;
    int         beat;
    logic       first_seen;
    logic       prev_stall;
    logic [3:0] prev_addr;
    logic       seen_done;
    r = tv[idx];
    @(negedge clk);
    use_cam     = r.use_cam;
    force_mbits = r.mbits;
    srch_key    = r.key;
    srch_req    = 1'b1;
    m_ready     = 1'b0;
    @(negedge clk);
    srch_req   = 1'b0;
    cyc        = 1;
    beat       = 0;
    first_seen = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = '0;
    seen_done  = 1'b0;
    while (!seen_done && cyc < 120) begin
      m_ready  = r.rdy[cyc % 16];
      srch_req = (r.inj == 2'd1 && cyc == 5);
      if (r.inj == 2'd1 && cyc == 5) srch_key = 6'h11;
      if (r.inj == 2'd2) begin
        cam_we_n = !(cyc == 5);
        cam_wa   = 4'd5;
        cam_din  = r.key;
      end
      chk("busy", 32'(srch_busy), 32'd1);
      chk("argin_hold", 32'(cam_argin), 32'(r.key));
      if (m_valid) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk("first_valid_latency", 32'(cyc), 32'(SETTLE + 2));
        end
        if (prev_stall) chk("stall_hold_addr", 32'(m_addr), 32'(prev_addr));
        if (beat < r.n) begin
          chk("m_addr", 32'(m_addr), 32'(r.addrs[beat*4 +: 4]));
          chk("m_last", 32'(m_last), 32'(beat == r.n - 1));
        end else begin
          chk("extra_beat", 32'(m_valid), 32'd0);
        end
        prev_stall = !m_ready;
        prev_addr  = m_addr;
        if (m_ready) beat++;
      end else begin
        prev_stall = 1'b0;
      end
      if (done) begin
        seen_done = 1'b1;
        chk("beat_count", 32'(beat), 32'(r.n));
        chk("hit", 32'(hit), 32'(r.hit));
        chk("match_cnt", 32'(match_cnt), 32'(r.cnt));
        if (r.n == 0) chk("done_latency", 32'(cyc), 32'(SETTLE + 2));
      end
      @(negedge clk);
      cyc++;
    end
    if (!seen_done) chk("done_timeout", 32'(done), 32'd1);
    srch_req = 1'b0;
    m_ready  = 1'b0;
    cam_we_n = 1'b1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_not_busy", 32'(srch_busy), 32'd0);
    chk("hit_hold", 32'(hit), 32'(r.hit));
    chk("cnt_hold", 32'(match_cnt), 32'(r.cnt));
    chk("argin_after", 32'(cam_argin), 32'(r.key));
    $display("search %0d key=0x%02h beats=%0d match_cnt=%0d hit=%0d cycles=%0d",
             idx, r.key, beat, match_cnt, hit, cyc);
  endtask

  initial begin
    rst_n       = 1'b1;
    srch_req    = 1'b0;
    srch_key    = '0;
    m_ready     = 1'b0;
    use_cam     = 1'b0;
    force_mbits = '0;
    cam_we_n    = 1'b1;
    cam_wa      = '0;
    cam_din     = '0;

    //                use  key    mbits     rdy       n   addrs                  cnt    hit  inj
    tv[0] = '{1'b0, 6'h15, 16'h0000, 16'hFFFF, 0,  64'h0,                  5'd0,  1'b0, 2'd0};
    tv[1] = '{1'b0, 6'h01, 16'hFFFF, 16'hFFFF, 16, 64'hFEDC_BA98_7654_3210, 5'd16, 1'b1, 2'd0};
    tv[2] = '{1'b0, 6'h02, 16'h8421, 16'hAAAA, 4,  64'h0000_0000_0000_FA50, 5'd4,  1'b1, 2'd0};
    tv[3] = '{1'b0, 6'h03, 16'h8000, 16'hFFFF, 1,  64'hF,                  5'd1,  1'b1, 2'd0};
    tv[4] = '{1'b0, 6'h04, 16'h0006, 16'h5555, 2,  64'h21,                 5'd2,  1'b1, 2'd0};
    tv[5] = '{1'b0, 6'h3E, 16'h8001, 16'h3333, 2,  64'hF0,                 5'd2,  1'b1, 2'd0};
    tv[6] = '{1'b0, 6'h2A, 16'h8421, 16'hFFCF, 4,  64'h0000_0000_0000_FA50, 5'd4,  1'b1, 2'd1};
    tv[7] = '{1'b1, 6'h3F, 16'h0000, 16'hFFFF, 1,  64'h5,                  5'd1,  1'b1, 2'd0};
    tv[8] = '{1'b1, 6'h15, 16'h0000, 16'hFFCF, 15, 64'h0FED_CBA9_8764_3210, 5'd15, 1'b1, 2'd2};
    tv[9] = '{1'b0, 6'h00, 16'h0000, 16'hFFFF, 0,  64'h0,                  5'd0,  1'b0, 2'd0};

    #2 rst_n = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_busy", 32'(srch_busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);
    chk("rst_argin", 32'(cam_argin), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Load the CAM: 0x15 everywhere, then 0x3F at entry 5
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      cam_we_n = 1'b0;
      cam_wa   = 4'(a);
      cam_din  = 6'h15;
    end
    @(negedge clk);
    cam_wa  = 4'd5;
    cam_din = 6'h3F;
    @(negedge clk);
    cam_we_n = 1'b1;

    for (int i = 0; i < NVEC; i++) run_search(i);

    // Asynchronous reset while addresses are being emitted
    @(negedge clk);
    use_cam     = 1'b0;
    force_mbits = 16'hFFFF;
    srch_key    = 6'h07;
    srch_req    = 1'b1;
    m_ready     = 1'b0;
    @(negedge clk);
    srch_req = 1'b0;
    for (int k = 0; k < 20 && !m_valid; k++) @(negedge clk);
    chk("midrst_reached_emit", 32'(m_valid), 32'd1);
    chk("midrst_cnt_before", 32'(match_cnt), 32'd16);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_busy", 32'(srch_busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hit", 32'(hit), 32'd0);
    chk("midrst_match_cnt", 32'(match_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
      chk("midrst_idle", 32'(srch_busy), 32'd0);
    end
    $display("reset mid-emit sequence complete");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
